// File: rtl/stopwatch_controller_if.sv
// Control, digit feedback and strobe bundle between the stopwatch controller and its surroundings.
// master = controller side, slave = counters/buttons/display side.
interface stopwatch_controller_if;
  logic       StartStop;
  logic       Clear;
  logic       Lap;
  logic [3:0] Digit0;
  logic [3:0] Digit1;
  logic [3:0] Digit2;
  logic [3:0] Digit3;
  logic [3:0] DigitEn;
  logic [3:0] DigitClr;
  logic       Running;
  logic       Frozen;
  logic       Overflow;

  modport master (
    input  StartStop, Clear, Lap, Digit0, Digit1, Digit2, Digit3,
    output DigitEn, DigitClr, Running, Frozen, Overflow
  );

  modport slave (
    output StartStop, Clear, Lap, Digit0, Digit1, Digit2, Digit3,
    input  DigitEn, DigitClr, Running, Frozen, Overflow
  );
endinterface

// File: rtl/stopwatch_controller.sv
// MM:SS stopwatch sequencer: run/pause/idle FSM, tick prescaler and BCD carry chain
// driving four external mod-10 digit counters through registered enable/clear strobes.
module stopwatch_controller #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input logic                    Clk,
  input logic                    nReset,
  stopwatch_controller_if.master sw
);
  localparam int unsigned PW        = $clog2(TICK_DIV);
  localparam int unsigned ND        = 4;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [ND-1:0] digit_en_q, digit_en_d;
  logic [ND-1:0] digit_clr_q, digit_clr_d;
  logic          running_q, running_d;
  logic          frozen_q, frozen_d;
  logic          overflow_q, overflow_d;

  logic          tick_c;
  logic [ND-1:0] carry_en_c;
  logic [ND-1:0] carry_clr_c;
  logic          carry_c;
  logic [3:0]    digit_v [ND];

  assign tick_c = (state_q == S_RUN) && (presc_q == TICK_LAST);

  // Ripple carry: a digit at (or beyond) its max clears and passes the carry on.
  always_comb begin
    digit_v[0]  = sw.Digit0;
    digit_v[1]  = sw.Digit1;
    digit_v[2]  = sw.Digit2;
    digit_v[3]  = sw.Digit3;
    carry_en_c  = '0;
    carry_clr_c = '0;
    carry_c     = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (carry_c && (digit_v[i] >= ((i == 1) ? 4'd5 : 4'd9))) begin
        carry_clr_c[i] = 1'b1;
      end else if (carry_c) begin
        carry_en_c[i] = 1'b1;
        carry_c       = 1'b0;
      end
    end
  end

  // Next state; carry_c here is the carry out of the top digit (wrap from 99:59).
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    digit_en_d  = '0;
    digit_clr_d = '0;
    frozen_d    = frozen_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      S_IDLE: begin
        presc_d = '0;
        if (sw.Clear) begin
          digit_clr_d = '1;
          frozen_d    = 1'b0;
          overflow_d  = 1'b0;
        end else if (sw.StartStop) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        presc_d = tick_c ? '0 : presc_q + PW'(1);
        if (tick_c) begin
          digit_en_d  = carry_en_c;
          digit_clr_d = carry_clr_c;
          if (carry_c) overflow_d = 1'b1;
        end
        if (sw.Lap) frozen_d = ~frozen_q;
        if (sw.StartStop) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (sw.Clear) begin
          state_d     = S_IDLE;
          presc_d     = '0;
          digit_clr_d = '1;
          frozen_d    = 1'b0;
          overflow_d  = 1'b0;
        end else if (sw.StartStop) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
        presc_d = '0;
      end
    endcase

    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      digit_en_q  <= '0;
      digit_clr_q <= '0;
      running_q   <= 1'b0;
      frozen_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      digit_en_q  <= digit_en_d;
      digit_clr_q <= digit_clr_d;
      running_q   <= running_d;
      frozen_q    <= frozen_d;
      overflow_q  <= overflow_d;
    end
  end

  assign sw.DigitEn  = digit_en_q;
  assign sw.DigitClr = digit_clr_q;
  assign sw.Running  = running_q;
  assign sw.Frozen   = frozen_q;
  assign sw.Overflow = overflow_q;
endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench for stopwatch_controller: emulated BCD counters, a seconds-based reference model
// feeding a strobe scoreboard, directed scenarios and a randomized button/preload phase.
module tb_stopwatch_controller;
  localparam int unsigned TICK_DIV = 4;

  typedef struct {
    int         cyc;
    logic [3:0] en;
    logic [3:0] clr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  stopwatch_controller_if sw_if ();

  stopwatch_controller #(.TICK_DIV(TICK_DIV)) dut (
    .Clk    (clk),
    .nReset (rst_n),
    .sw     (sw_if)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  logic m_run = 1'b0;
  logic m_frz = 1'b0;
  logic m_ovf = 1'b0;

  // External mod-10 counters with a bench preload port
  logic [3:0] cnt [4];
  logic [3:0] load_val [4];
  logic       load_req;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (load_req)                 cnt[i] <= load_val[i];
      else if (sw_if.DigitClr[i])   cnt[i] <= 4'd0;
      else if (sw_if.DigitEn[i])    cnt[i] <= (cnt[i] == 4'd9) ? 4'd0 : cnt[i] + 4'd1;
    end
  end

  assign sw_if.Digit0 = cnt[0];
  assign sw_if.Digit1 = cnt[1];
  assign sw_if.Digit2 = cnt[2];
  assign sw_if.Digit3 = cnt[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: elapsed time as seconds, strobes derived from old vs new digit values
  initial begin : model
    int   st;
    int   phase;
    int   s;
    int   nx;
    int   mx;
    int   d [4];
    int   nd [4];
    exp_t e;
    st = 0;
    phase = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n !== 1'b1) begin
        st = 0; phase = 0; m_frz = 1'b0; m_ovf = 1'b0;
        exp_q.delete();
      end else if (st != 1 && sw_if.Clear) begin
        st = 0; phase = 0; m_frz = 1'b0; m_ovf = 1'b0;
        e.cyc = cyc; e.en = 4'h0; e.clr = 4'hF;
        exp_q.push_back(e);
      end else if (st == 0) begin
        phase = 0;
        if (sw_if.StartStop) st = 1;
      end else if (st == 2) begin
        if (sw_if.StartStop) st = 1;
      end else begin
        if (sw_if.Lap) m_frz = !m_frz;
        if (phase == int'(TICK_DIV) - 1) begin
          for (int i = 0; i < 4; i++) begin
            mx = (i == 1) ? 5 : 9;
            d[i] = int'(cnt[i]);
            if (d[i] > mx) d[i] = mx;
          end
          s = d[0] + 10 * d[1] + 60 * d[2] + 600 * d[3];
          if (s == 5999) m_ovf = 1'b1;
          nx = (s + 1) % 6000;
          nd[0] = nx % 10;
          nd[1] = (nx / 10) % 6;
          nd[2] = (nx / 60) % 10;
          nd[3] = nx / 600;
          e.cyc = cyc; e.en = 4'h0; e.clr = 4'h0;
          for (int i = 0; i < 4; i++) begin
            if (nd[i] != d[i]) begin
              if (nd[i] == 0) e.clr[i] = 1'b1;
              else            e.en[i]  = 1'b1;
            end
          end
          exp_q.push_back(e);
          phase = 0;
        end else begin
          phase++;
        end
        if (sw_if.StartStop) st = 2;
      end
      m_run = (st == 1);
    end
  end

  // Monitor: pops expected strobes whenever the DUT presents one, checks status flags
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          check("strobe_missing", 32'(0), 32'({e.en, e.clr}));
        end
        if (sw_if.DigitEn != 4'h0 || sw_if.DigitClr != 4'h0) begin
          if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
            check("strobe_spurious", 32'({sw_if.DigitEn, sw_if.DigitClr}), 32'(0));
          end else begin
            e = exp_q.pop_front();
            check("sb_digit_en", 32'(sw_if.DigitEn), 32'(e.en));
            check("sb_digit_clr", 32'(sw_if.DigitClr), 32'(e.clr));
            check("sb_en_clr_overlap", 32'(sw_if.DigitEn & sw_if.DigitClr), 32'(0));
          end
        end
        check("sb_running", 32'(sw_if.Running), 32'(m_run));
        check("sb_frozen", 32'(sw_if.Frozen), 32'(m_frz));
        check("sb_overflow", 32'(sw_if.Overflow), 32'(m_ovf));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic ss, input logic clr, input logic lap);
    sw_if.StartStop = ss;
    sw_if.Clear     = clr;
    sw_if.Lap       = lap;
    @(posedge clk);
    #1;
    sw_if.StartStop = 1'b0;
    sw_if.Clear     = 1'b0;
    sw_if.Lap       = 1'b0;
  endtask

  task automatic load_digits(input logic [3:0] d3, input logic [3:0] d2,
                             input logic [3:0] d1, input logic [3:0] d0);
    load_val[0] = d0; load_val[1] = d1; load_val[2] = d2; load_val[3] = d3;
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
  endtask

  // Returns at the negedge where a strobe is visible; n = posedges waited, -1 on timeout
  task automatic wait_strobe(input int budget, output int n,
                             output logic [3:0] en, output logic [3:0] clr);
    n = -1; en = 4'h0; clr = 4'h0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (sw_if.DigitEn != 4'h0 || sw_if.DigitClr != 4'h0) begin
        n = k; en = sw_if.DigitEn; clr = sw_if.DigitClr;
        break;
      end
    end
  endtask

  // From RUN: pause, preload digits, resume and check the first carry pattern
  task automatic digit_case(input string name, input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0,
                            input logic [3:0] exp_clr, input logic [3:0] exp_en);
    int n; logic [3:0] en; logic [3:0] clr;
    sync();
    pulse(1'b1, 1'b0, 1'b0);
    load_digits(d3, d2, d1, d0);
    pulse(1'b1, 1'b0, 1'b0);
    wait_strobe(8, n, en, clr);
    check({name, "_seen"}, 32'(n > 0), 32'(1));
    check({name, "_clr"}, 32'(clr), 32'(exp_clr));
    check({name, "_en"}, 32'(en), 32'(exp_en));
  endtask

  initial begin : stim
    int n; logic [3:0] en; logic [3:0] clr;
    rst_n = 1'b0;
    sw_if.StartStop = 1'b0;
    sw_if.Clear     = 1'b0;
    sw_if.Lap       = 1'b0;
    for (int i = 0; i < 4; i++) load_val[i] = 4'd0;
    load_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    load_req = 1'b0;
    sync();
    check("rst_digit_en", 32'(sw_if.DigitEn), 32'(0));
    check("rst_digit_clr", 32'(sw_if.DigitClr), 32'(0));
    check("rst_running", 32'(sw_if.Running), 32'(0));
    check("rst_frozen", 32'(sw_if.Frozen), 32'(0));
    check("rst_overflow", 32'(sw_if.Overflow), 32'(0));

    // Start from 00:00 and check tick spacing
    pulse(1'b1, 1'b0, 1'b0);
    check("start_running", 32'(sw_if.Running), 32'(1));
    wait_strobe(10, n, en, clr);
    check("first_tick_latency", 32'(n), 32'(4));
    check("first_tick_en", 32'(en), 32'(1));
    check("first_tick_clr", 32'(clr), 32'(0));
    for (int r = 0; r < 2; r++) begin
      wait_strobe(10, n, en, clr);
      check("tick_period", 32'(n), 32'(4));
    end

    // Pause with prescaler at 2, then resume
    sync();
    pulse(1'b1, 1'b0, 1'b0);
    check("pause_running", 32'(sw_if.Running), 32'(0));
    for (int k = 0; k < 10; k++) begin
      sync();
      check("pause_no_strobe", 32'({sw_if.DigitEn, sw_if.DigitClr}), 32'(0));
    end
    pulse(1'b1, 1'b0, 1'b0);
    wait_strobe(10, n, en, clr);
    check("resume_latency", 32'(n), 32'(2));
    check("resume_en", 32'(en), 32'(1));

    // Carry patterns
    digit_case("c_00_09", 4'd0, 4'd0, 4'd0, 4'd9, 4'b0001, 4'b0010);
    digit_case("c_03_59", 4'd0, 4'd3, 4'd5, 4'd9, 4'b0011, 4'b0100);
    digit_case("c_09_59", 4'd0, 4'd9, 4'd5, 4'd9, 4'b0111, 4'b1000);
    digit_case("c_oor_d1", 4'd0, 4'd0, 4'd7, 4'd9, 4'b0011, 4'b0100);
    digit_case("c_99_59", 4'd9, 4'd9, 4'd5, 4'd9, 4'b1111, 4'b0000);
    check("wrap_overflow", 32'(sw_if.Overflow), 32'(1));
    for (int r = 0; r < 3; r++) wait_strobe(10, n, en, clr);
    check("overflow_sticky", 32'(sw_if.Overflow), 32'(1));
    sync();
    pulse(1'b0, 1'b1, 1'b0);
    check("clear_in_run_ovf", 32'(sw_if.Overflow), 32'(1));
    check("clear_in_run_clr", 32'(sw_if.DigitClr), 32'(0));
    check("clear_in_run_running", 32'(sw_if.Running), 32'(1));

    // Lap toggling, then combined Clear+StartStop in PAUSE
    pulse(1'b0, 1'b0, 1'b1);
    check("lap1_frozen", 32'(sw_if.Frozen), 32'(1));
    pulse(1'b0, 1'b0, 1'b1);
    check("lap2_frozen", 32'(sw_if.Frozen), 32'(0));
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0);
    check("pause_keeps_frozen", 32'(sw_if.Frozen), 32'(1));
    pulse(1'b1, 1'b1, 1'b0);
    check("clr_ss_running", 32'(sw_if.Running), 32'(0));
    check("clr_ss_frozen", 32'(sw_if.Frozen), 32'(0));
    check("clr_ss_overflow", 32'(sw_if.Overflow), 32'(0));
    check("clr_ss_digitclr", 32'(sw_if.DigitClr), 32'(4'hF));
    check("clr_ss_digiten", 32'(sw_if.DigitEn), 32'(0));
    sync();
    check("clr_one_cycle", 32'(sw_if.DigitClr), 32'(0));
    pulse(1'b0, 1'b0, 1'b1);
    check("lap_idle_ignored", 32'(sw_if.Frozen), 32'(0));

    // Reset in the middle of a strobe
    pulse(1'b1, 1'b0, 1'b0);
    wait_strobe(10, n, en, clr);
    check("pre_reset_strobe", 32'(en), 32'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_en", 32'(sw_if.DigitEn), 32'(0));
    check("async_rst_running", 32'(sw_if.Running), 32'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sync();
    check("post_rst_running", 32'(sw_if.Running), 32'(0));

    // Random buttons and preloads; scoreboard does the checking
    for (int k = 0; k < 3000; k++) begin
      sw_if.StartStop = ($urandom_range(0, 24) == 0);
      sw_if.Clear     = ($urandom_range(0, 39) == 0);
      sw_if.Lap       = ($urandom_range(0, 19) == 0);
      load_req        = ($urandom_range(0, 149) == 0);
      if (load_req) begin
        for (int i = 0; i < 4; i++) begin
          if ($urandom_range(0, 2) != 0) load_val[i] = (i == 1) ? 4'd5 : 4'd9;
          else                           load_val[i] = 4'($urandom_range(0, 15));
        end
      end
      sync();
    end
    sw_if.StartStop = 1'b0;
    sw_if.Clear     = 1'b0;
    sw_if.Lap       = 1'b0;
    load_req        = 1'b0;
    repeat (4) sync();
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
